// File: rtl/sys_bridge_pkg.sv
// sys_bridge_pkg
// Shared definitions for the M-stage bridge: address map bounds, FSM state
// encoding, the device-select bundle and a range helper.
// No ports (package).

package sys_bridge_pkg;

  // Inclusive address windows.
  localparam logic [31:0] DM_START_ADDR   = 32'h0000_0000;
  localparam logic [31:0] DM_END_ADDR     = 32'h0000_2FFF;
  localparam logic [31:0] TC_START_ADDR   = 32'h0000_7F00;
  localparam logic [31:0] TC_END_ADDR     = 32'h0000_7F0B;
  localparam logic [31:0] UART_START_ADDR = 32'h0000_7F30;
  localparam logic [31:0] UART_END_ADDR   = 32'h0000_7F3F;
  localparam logic [31:0] LED_START_ADDR  = 32'h0000_7F70;
  localparam logic [31:0] LED_END_ADDR    = 32'h0000_7F73;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } bridge_state_e;

  // One-hot device selects; unmapped is set when no window matches.
  typedef struct packed {
    logic dm;
    logic tc;
    logic uart;
    logic led;
    logic unmapped;
  } dev_sel_t;

  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/sys_addr_decode.sv
// sys_addr_decode
// Combinational address decoder: byte address -> one-hot device select plus
// an unmapped flag.
// Ports:
//   addr_i  in  32  byte address from the M stage
//   sel_o   out     dev_sel_t select bundle

module sys_addr_decode
  import sys_bridge_pkg::*;
(
  input  logic [31:0] addr_i,
  output dev_sel_t    sel_o
);

  always_comb begin
    sel_o          = '0;
    sel_o.dm       = in_range(addr_i, DM_START_ADDR,   DM_END_ADDR);
    sel_o.tc       = in_range(addr_i, TC_START_ADDR,   TC_END_ADDR);
    sel_o.uart     = in_range(addr_i, UART_START_ADDR, UART_END_ADDR);
    sel_o.led      = in_range(addr_i, LED_START_ADDR,  LED_END_ADDR);
    sel_o.unmapped = ~(sel_o.dm | sel_o.tc | sel_o.uart | sel_o.led);
  end

endmodule

// File: rtl/sys_bridge.sv
// sys_bridge
// Address-decoding bridge from the CPU M-stage data port to DM, TC0, UART and
// an internal LED register. DM/TC0/LED are zero-wait-state; UART uses a
// req/ack handshake and stalls the CPU until the ack arrives.
//
// Build option: define BRIDGE_TIMEOUT_EN to abort a UART access that waits
// UART_TIMEOUT cycles without ack (bus error, read data 0). Without it the
// bridge waits for the ack indefinitely.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cpu_addr/wdata/byteen/rd         M-stage request (held stable while stalled)
//   cpu_rdata/stall/buserr           response to the M stage
//   dm_addr/wdata/byteen, dm_rdata   data memory
//   tc_addr/we/wdata, tc_rdata       timer TC0
//   uart_req/we/addr/wdata           UART request
//   uart_ack, uart_rdata             UART completion (rdata valid with ack)
//   led_out                          LED register
//
// State table
//   state | meaning
//   IDLE  | no UART transfer pending; zero-wait devices served directly
//   WAIT  | UART request outstanding, CPU stalled
//   DONE  | one-cycle completion: latched UART data/error shown, stall released

module sys_bridge
  import sys_bridge_pkg::*;
#(
  parameter int unsigned UART_TIMEOUT = 255,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  input  logic        cpu_rd,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        cpu_buserr,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byteen,
  input  logic [31:0] dm_rdata,
  output logic [31:0] tc_addr,
  output logic        tc_we,
  output logic [31:0] tc_wdata,
  input  logic [31:0] tc_rdata,
  output logic        uart_req,
  output logic        uart_we,
  output logic [3:0]  uart_addr,
  output logic [31:0] uart_wdata,
  input  logic        uart_ack,
  input  logic [31:0] uart_rdata,
  output logic [31:0] led_out
);

  dev_sel_t      sel;
  logic          is_store;
  logic          access;
  logic          uart_hit;
  logic          timeout;

  bridge_state_e state_q, state_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q,   err_d;
  logic [31:0]   led_q,   led_d;

  sys_addr_decode u_decode (
    .addr_i (cpu_addr),
    .sel_o  (sel)
  );

  assign is_store = |cpu_byteen;
  assign access   = cpu_rd | is_store;
  assign uart_hit = access & sel.uart;

`ifdef BRIDGE_TIMEOUT_EN
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(UART_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts WAIT cycles only; cleared in every other state.
  assign cnt_d   = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
  assign timeout = (state_q == WAIT) && (cnt_q == CntLast);

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = UART_TIMEOUT ^ CNT_W;
  assign timeout    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      err_q   <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      led_q   <= led_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (uart_hit) begin
          if (uart_ack) begin
            state_d = DONE;
            rdata_d = uart_rdata;
            err_d   = 1'b0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // An ack in the timeout cycle still completes normally.
        if (uart_ack) begin
          state_d = DONE;
          rdata_d = uart_rdata;
          err_d   = 1'b0;
        end else if (timeout) begin
          state_d = DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // LED byte-lane writes
  always_comb begin
    led_d = led_q;
    for (int b = 0; b < 4; b++) begin
      if (sel.led && cpu_byteen[b]) led_d[8*b +: 8] = cpu_wdata[8*b +: 8];
    end
  end

  // Outputs
  always_comb begin
    uart_req   = 1'b0;
    cpu_stall  = 1'b0;
    cpu_buserr = access & sel.unmapped;
    case (state_q)
      IDLE: begin
        uart_req  = uart_hit;
        cpu_stall = uart_hit;
      end
      WAIT: begin
        uart_req  = 1'b1;
        cpu_stall = 1'b1;
      end
      DONE: begin
        // Request is still on the bus here but must not be reissued.
        cpu_buserr = err_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    cpu_rdata = '0;
    if (state_q == DONE) cpu_rdata = rdata_q;
    else if (sel.dm)     cpu_rdata = dm_rdata;
    else if (sel.tc)     cpu_rdata = tc_rdata;
    else if (sel.led)    cpu_rdata = led_q;
  end

  assign dm_addr    = cpu_addr;
  assign dm_wdata   = cpu_wdata;
  assign dm_byteen  = sel.dm ? cpu_byteen : 4'b0000;

  assign tc_addr    = cpu_addr;
  assign tc_wdata   = cpu_wdata;
  assign tc_we      = sel.tc & (cpu_byteen == 4'hF);

  assign uart_we    = uart_req & is_store;
  assign uart_addr  = cpu_addr[3:0];
  assign uart_wdata = cpu_wdata;

  assign led_out    = led_q;

endmodule

// File: tb/tb_sys_bridge.sv
module tb_sys_bridge;

  localparam int TO = 4;
`ifdef BRIDGE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_byteen = '0;
  logic        cpu_rd = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, cpu_buserr;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_byteen;
  logic [31:0] tc_addr, tc_wdata, tc_rdata;
  logic        tc_we;
  logic        uart_req, uart_we;
  logic [3:0]  uart_addr;
  logic [31:0] uart_wdata;
  logic        uart_ack = 1'b0;
  logic [31:0] uart_rdata = '0;
  logic [31:0] led_out;

  sys_bridge #(.UART_TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_byteen(cpu_byteen), .cpu_rd(cpu_rd),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_buserr(cpu_buserr),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_byteen(dm_byteen), .dm_rdata(dm_rdata),
    .tc_addr(tc_addr), .tc_we(tc_we), .tc_wdata(tc_wdata), .tc_rdata(tc_rdata),
    .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_ack(uart_ack), .uart_rdata(uart_rdata), .led_out(led_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Devices: DM memory written by the DUT's outputs; TC returns an address hash.
  logic [31:0] dev_mem [64];
  logic [31:0] ref_mem [64];
  assign dm_rdata = dev_mem[dm_addr[7:2]];
  assign tc_rdata = 32'h7C00_0000 ^ tc_addr;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (dm_byteen[b]) dev_mem[dm_addr[7:2]][8*b +: 8] = dm_wdata[8*b +: 8];
  end

  // 0 DM, 1 TC0, 2 UART, 3 LED, 4 unmapped
  function automatic int region(input logic [31:0] a);
    if (a <= 32'h0000_2FFF) return 0;
    if (a >= 32'h0000_7F00 && a <= 32'h0000_7F0B) return 1;
    if (a >= 32'h0000_7F30 && a <= 32'h0000_7F3F) return 2;
    if (a >= 32'h0000_7F70 && a <= 32'h0000_7F73) return 3;
    return 4;
  endfunction

  // Reference model: a pending UART transfer is described by how many cycles
  // it has been outstanding and whether this is its completion cycle.
  bit          m_done = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_data = '0;
  logic        m_err = 1'b0;
  logic [31:0] ref_led = '0;
  logic        stall_seen = 1'b0;

  int          rg;
  logic        acc, ld, st, exp_req;
  logic [31:0] exp_rd;

  always @(negedge clk) begin
    if (reset) begin
      m_done  = 1'b0;
      m_cnt   = 0;
      ref_led = '0;
    end else begin
      rg      = region(cpu_addr);
      st      = |cpu_byteen;
      ld      = cpu_rd & ~st;
      acc     = cpu_rd | st;
      exp_req = !m_done && acc && (rg == 2);
      chk("stall", cpu_stall, exp_req);
      chk("uart_req", uart_req, exp_req);
      chk("uart_we", uart_we, exp_req && st);
      chk("buserr", cpu_buserr, m_done ? m_err : (acc && rg == 4));
      chk("dm_byteen", dm_byteen, (rg == 0) ? cpu_byteen : 4'h0);
      chk("tc_we", tc_we, (rg == 1) && (cpu_byteen == 4'hF));
      chk("led_out", led_out, ref_led);
      if (exp_req) chk("uart_addr", uart_addr, cpu_addr[3:0]);
      if (m_done) begin
        chk("done_rdata", cpu_rdata, m_data);
      end else if (ld && !exp_req) begin
        case (rg)
          0:       exp_rd = ref_mem[cpu_addr[7:2]];
          1:       exp_rd = 32'h7C00_0000 ^ cpu_addr;
          3:       exp_rd = ref_led;
          default: exp_rd = '0;
        endcase
        chk("load_rdata", cpu_rdata, exp_rd);
      end
      for (int b = 0; b < 4; b++) begin
        if (cpu_byteen[b] && rg == 0) ref_mem[cpu_addr[7:2]][8*b +: 8] = cpu_wdata[8*b +: 8];
        if (cpu_byteen[b] && rg == 3) ref_led[8*b +: 8] = cpu_wdata[8*b +: 8];
      end
      if (m_done) begin
        m_done = 1'b0;
        m_cnt  = 0;
      end else if (acc && rg == 2) begin
        if (uart_ack) begin
          m_done = 1'b1; m_data = uart_rdata; m_err = 1'b0;
        end else if (TO_EN && m_cnt == TO) begin
          m_done = 1'b1; m_data = '0; m_err = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end
    stall_seen = cpu_stall;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    cpu_rd = rd; cpu_byteen = be; cpu_addr = a; cpu_wdata = wd;
  endtask

  // Called at posedge+1; returns in the completion cycle (posedge+3).
  task automatic uart_txn(input logic [31:0] addr, input logic [3:0] be, input int ack_at,
                          input logic [31:0] ack_data, output int stall_n, output int req_n,
                          output logic [31:0] rd_out, output logic err_out, output logic fin);
    stall_n = 0; req_n = 0; rd_out = '0; err_out = 1'b0; fin = 1'b0;
    drive(be == 4'h0, be, addr, 32'h5A5A_1234);
    for (int k = 0; k < 40; k++) begin
      uart_ack   = (k == ack_at);
      uart_rdata = (k == ack_at) ? ack_data : 32'hBAD0_0000 + 32'(k);
      #2;
      if (cpu_stall) stall_n++;
      if (uart_req)  req_n++;
      if (!cpu_stall) begin
        rd_out = cpu_rdata; err_out = cpu_buserr; fin = 1'b1;
        break;
      end
      step();
    end
    uart_ack = 1'b0;
  endtask

  logic [31:0] bnd [13] = '{32'h2FFC, 32'h2FFF, 32'h3000, 32'h7EFF, 32'h7F0B, 32'h7F0C,
                            32'h7F2F, 32'h7F30, 32'h7F3F, 32'h7F40, 32'h7F6F, 32'h7F73, 32'h7F74};

  int          s_n, r_n;
  logic [31:0] t_rd;
  logic        t_err, t_fin;
  logic [31:0] v, a;
  int          r;

  initial begin
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      dev_mem[i] = v;
      ref_mem[i] = v;
    end
    step(); step();
    reset = 1'b0;
    #2;
    chk("rst_led", led_out, 32'h0);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_req", uart_req, 1'b0);
    chk("rst_buserr", cpu_buserr, 1'b0);

    // DM store then load
    step(); drive(0, 4'hF, 32'h10, 32'hDEADBEEF); #2;
    chk("sw_dm_byteen", dm_byteen, 4'hF);
    chk("sw_dm_stall", cpu_stall, 1'b0);
    step(); drive(1, 4'h0, 32'h10, 32'h0); #2;
    chk("lw_dm_rdata", cpu_rdata, 32'hDEADBEEF);

    // LED byte write, then reset clears it
    step(); drive(0, 4'b0010, 32'h7F71, 32'h0000A500);
    step(); drive(0, 4'h0, 32'h0, 32'h0); #2;
    chk("led_write", led_out, 32'h0000A500);
    step(); drive(1, 4'h0, 32'h7F70, 32'h0); #2;
    chk("led_load", cpu_rdata, 32'h0000A500);
    step(); drive(0, 4'h0, 32'h0, 32'h0); reset = 1'b1;
    step(); reset = 1'b0; #2;
    chk("led_reset", led_out, 32'h0);

    // UART load, ack on the 4th request cycle
    step(); uart_txn(32'h7F30, 4'h0, 3, 32'h41, s_n, r_n, t_rd, t_err, t_fin);
    chk("u_fin", t_fin, 1'b1);
    chk("u_stall_cycles", s_n, 4);
    chk("u_req_cycles", r_n, 4);
    chk("u_done_rdata", t_rd, 32'h41);
    chk("u_done_err", t_err, 1'b0);
    step(); drive(0, 4'h0, 32'h0, 32'h0);

    // UART store acked immediately
    step(); uart_txn(32'h7F38, 4'hF, 0, 32'h66, s_n, r_n, t_rd, t_err, t_fin);
    chk("us_stall_cycles", s_n, 1);
    chk("us_done_rdata", t_rd, 32'h66);
    step(); drive(0, 4'h0, 32'h0, 32'h0);

    // Unmapped and TC0 accesses
    step(); drive(1, 4'h0, 32'h5000, 32'h0); #2;
    chk("unm_buserr", cpu_buserr, 1'b1);
    chk("unm_rdata", cpu_rdata, 32'h0);
    chk("unm_stall", cpu_stall, 1'b0);
    step(); drive(0, 4'hF, 32'h5000, 32'h1234); #2;
    chk("unm_dm_byteen", dm_byteen, 4'h0);
    chk("unm_tc_we", tc_we, 1'b0);
    step(); drive(0, 4'hF, 32'h7F04, 32'h1); #2;
    chk("tc_we_full", tc_we, 1'b1);
    step(); drive(0, 4'h3, 32'h7F04, 32'h1); #2;
    chk("tc_we_partial", tc_we, 1'b0);
    step(); drive(1, 4'h0, 32'h7F08, 32'h0); #2;
    chk("tc_load", cpu_rdata, 32'h7C00_7F08);
    step(); drive(1, 4'h0, 32'h7F0C, 32'h0); #2;
    chk("tc_edge_buserr", cpu_buserr, 1'b1);
    step(); drive(0, 4'h0, 32'h0, 32'h0);

`ifdef BRIDGE_TIMEOUT_EN
    step(); uart_txn(32'h7F34, 4'h0, -1, 32'h0, s_n, r_n, t_rd, t_err, t_fin);
    chk("to_stall_cycles", s_n, TO + 1);
    chk("to_buserr", t_err, 1'b1);
    chk("to_rdata", t_rd, 32'h0);
    step(); drive(0, 4'h0, 32'h0, 32'h0);
    step(); uart_txn(32'h7F34, 4'h0, TO, 32'h77, s_n, r_n, t_rd, t_err, t_fin);
    chk("to_tie_stall", s_n, TO + 1);
    chk("to_tie_err", t_err, 1'b0);
    chk("to_tie_rdata", t_rd, 32'h77);
    step(); drive(0, 4'h0, 32'h0, 32'h0);
`else
    step(); uart_txn(32'h7F34, 4'h0, 12, 32'h99, s_n, r_n, t_rd, t_err, t_fin);
    chk("long_stall_cycles", s_n, 13);
    chk("long_err", t_err, 1'b0);
    chk("long_rdata", t_rd, 32'h99);
    step(); drive(0, 4'h0, 32'h0, 32'h0);
`endif

    // Reset while waiting; a late ack must be ignored
    step(); drive(1, 4'h0, 32'h7F34, 32'h0); #2;
    chk("rw_req0", uart_req, 1'b1);
    step();
    step(); reset = 1'b1; drive(0, 4'h0, 32'h0, 32'h0);
    step(); reset = 1'b0; uart_ack = 1'b1; uart_rdata = 32'hEE; #2;
    chk("rw_req_dropped", uart_req, 1'b0);
    chk("rw_stall_dropped", cpu_stall, 1'b0);
    step(); uart_ack = 1'b1; uart_rdata = 32'h5E; drive(1, 4'h0, 32'h7F34, 32'h0); #2;
    chk("rw_new_req", uart_req, 1'b1);
    chk("rw_new_stall", cpu_stall, 1'b1);
    step(); uart_ack = 1'b0; #2;
    chk("rw_done_rdata", cpu_rdata, 32'h5E);
    step(); drive(0, 4'h0, 32'h0, 32'h0);

    // Randomized traffic, CPU holds its request while stalled
    for (int c = 0; c < 4000; c++) begin
      step();
      if (!stall_seen) begin
        r = $urandom_range(0, 9);
        case (r)
          0:       a = $urandom;
          1, 2:    a = $urandom_range(0, 255);
          3:       a = 32'h7F00 + $urandom_range(0, 11);
          4, 5:    a = 32'h7F30 + $urandom_range(0, 15);
          6:       a = 32'h7F70 + $urandom_range(0, 3);
          7, 9:    a = bnd[$urandom_range(0, 12)];
          default: a = $urandom;
        endcase
        if (r == 0)                     drive(0, 4'h0, a, $urandom);
        else if ($urandom_range(0, 1))  drive(1, 4'h0, a, $urandom);
        else if ($urandom_range(0, 2) == 0) drive(0, 4'hF, a, $urandom);
        else                            drive(0, 4'($urandom_range(1, 15)), a, $urandom);
      end
      uart_ack   = ($urandom_range(0, 3) == 0);
      uart_rdata = $urandom;
    end
    step(); drive(0, 4'h0, 32'h0, 32'h0); uart_ack = 1'b0;
    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule
